palette_ram_fader: RTL and testbench
====================================

// Module: palette_ram_fader
// PURPOSE
//  Programmable, multi-bank successor to the fixed colour-lookup palettes used by the sprite renderers.
//  Maps a pixel colour index to a 12-bit RGB value through a writable palette RAM.
//  Applies a global brightness scale driven by a timed fade-in/fade-out engine.
//  Sits between the sprite/background pixel mux and the VGA output register; the game FSM drives the write and fade ports.
// PARAMETERS
//  NUM_ENTRIES  32            colours per bank; IDX_W = $clog2(NUM_ENTRIES)
//  NUM_BANKS    2             independent palettes (level/character swaps); BANK_W = max(1,$clog2(NUM_BANKS))
//  CH_W         4             bits per colour channel
//  FADE_DIV     262144        clk cycles per brightness step (>=1)
//  INIT_FILE    "palette.hex" $readmemh image loaded at configuration, bank-major
// PORTS
//  clk          in   1          system clock
//  reset        in   1          synchronous, active-high
//  pix_valid    in   1          lookup request this cycle
//  pix_bank     in   BANK_W     bank select for lookup
//  pix_index    in   IDX_W      colour index for lookup
//  wr_en        in   1          palette write strobe
//  wr_bank      in   BANK_W     bank to write
//  wr_addr      in   IDX_W      entry to write
//  wr_data      in   3*CH_W     {red,green,blue}
//  fade_start   in   1          start a fade (accepted only when idle)
//  fade_dir     in   1          1 = fade in (to full), 0 = fade out (to black)
//  red,green,blue out CH_W      scaled colour, registered
//  out_valid    out  1          pix_valid delayed by 2
//  fade_busy    out  1          fade engine active
//  fade_done    out  1          one-cycle pulse when fade reaches target
// BEHAVIOUR
//  Reset: red/green/blue=0, out_valid=0, fade_busy=0, fade_done=0, level=16, state IDLE, divider=0. RAM contents untouched by reset.
//  Lookup latency 2: cycle N request -> cycle N+1 RAM read registered -> cycle N+2 scaled result on outputs with out_valid=1.
//  Fully pipelined: one lookup per cycle, no stall. When out_valid=0, colour outputs hold their last value.
//  Lookup with bank>=NUM_BANKS or index>=NUM_ENTRIES yields colour 0.
//  Writes: single cycle, always accepted; out-of-range bank/addr are dropped.
//  Write and lookup to the same entry in the same cycle: the lookup returns the OLD data (read-before-write).
//  Scaling: ch_out = (ch * level) >> 4, with level in 0..16 (5 bits) and a 9-bit product.
//    level 16 gives an exact pass-through (15*16>>4=15); level 0 gives black.
//    level is sampled in the scale stage (cycle N+1).
//  Fade FSM states: IDLE, STEP.
//    IDLE + fade_start: latch dir, clear divider, fade_busy=1, enter STEP.
//    If level already equals the target (16 for in, 0 for out): pulse fade_done the next cycle and return to IDLE without stepping.
//    STEP: divider counts 0..FADE_DIV-1. On wrap, level += 1 (in) or -= 1 (out).
//    When the new level equals the target: fade_done=1 for one cycle, fade_busy=0, go to IDLE.
//    A full fade therefore takes 16*FADE_DIV cycles.
//  fade_start while busy is ignored; dir is not re-latched.
//  Reset mid-fade: immediate return to IDLE, level=16, no fade_done pulse.
// CONFIGURATION
//  PALETTE_TRANSPARENCY_EN defined:
//    adds output port `transparent` (1 bit, reset 0), aligned with out_valid.
//    transparent=1 when the looked-up index==0, regardless of bank.
//    Colour outputs still carry entry 0, scaled.
//  PALETTE_TRANSPARENCY_EN undefined: the port and its logic are absent; entry 0 is an ordinary colour.
// TESTING
//  Write bank0 addr5=12'hA43; lookup bank0 idx5 at cycle N -> cycle N+2 out_valid=1, {r,g,b}=A,4,3.
//  Same-cycle write 12'h123 and lookup of bank1 addr7 (old 12'hFFF) -> FFF returned; lookup next cycle -> 123.
//  FADE_DIV=4, fade_start dir=0 -> level 15 after 4 cycles, fade_done pulse at cycle 64, then entry FFF reads 000.
//  At level 8, entry 12'hF84 -> 7,4,2; fade_start mid-fade ignored; fade in from 0 ends at level 16 after 64 cycles.
//  Assert reset at cycle 20 of a fade -> level=16, fade_busy=0, no fade_done; back-to-back lookups 0..31 stream out unchanged.
//  With PALETTE_TRANSPARENCY_EN: lookup idx0 -> transparent=1 at N+2; idx1 -> 0; bank=NUM_BANKS -> colour 000.

Source files
------------

// File: rtl/palette_ram_fader.sv
// Banked palette lookup with a 2-stage pipeline and a timed global brightness fade.
// Optional `PALETTE_TRANSPARENCY_EN adds a `transparent` output flagging index 0.
module palette_ram_fader #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned CH_W        = 4,
  parameter int unsigned FADE_DIV    = 262144,
  localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES),
  localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [BANK_W-1:0] pix_bank,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0] wr_data,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_valid,
  output logic              fade_busy,
  output logic              fade_done
`ifdef PALETTE_TRANSPARENCY_EN
  ,
  output logic              transparent
`endif
);

  localparam int unsigned COL_W = 3 * CH_W;
  localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [4:0]  FULL  = 5'd16;

  typedef enum logic {IDLE, STEP} fade_state_t;

  logic [COL_W-1:0] mem [NUM_BANKS][NUM_ENTRIES];
  logic [COL_W-1:0] rd_color;
  logic             rd_valid;
  logic             pix_hit;
  logic             wr_hit;

  fade_state_t      state;
  logic [4:0]       level;
  logic [4:0]       target;
  logic [4:0]       next_level;
  logic [DIV_W-1:0] div;
  logic             fade_in;

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch, input logic [4:0] lvl);
    logic [CH_W+4:0] prod;
    prod = (CH_W+5)'(ch) * (CH_W+5)'(lvl);
    return CH_W'(prod >> 4);
  endfunction

  always_comb begin
    pix_hit = (32'(pix_bank) < NUM_BANKS) && (32'(pix_index) < NUM_ENTRIES);
    wr_hit  = wr_en && (32'(wr_bank) < NUM_BANKS) && (32'(wr_addr) < NUM_ENTRIES);
  end

  // Read and write share one block so a same-cycle lookup sees the pre-write data.
  always_ff @(posedge clk) begin
    if (wr_hit)
      mem[wr_bank][wr_addr] <= wr_data;
    if (pix_valid)
      rd_color <= pix_hit ? mem[pix_bank][pix_index] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_valid <= 1'b0;
    else
      rd_valid <= pix_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      if (rd_valid) begin
        red   <= scale(rd_color[3*CH_W-1:2*CH_W], level);
        green <= scale(rd_color[2*CH_W-1:CH_W], level);
        blue  <= scale(rd_color[CH_W-1:0], level);
      end
    end
  end

`ifdef PALETTE_TRANSPARENCY_EN
  logic idx_zero;

  always_ff @(posedge clk) begin
    if (pix_valid)
      idx_zero <= (pix_index == '0);
  end

  always_ff @(posedge clk) begin
    if (reset)
      transparent <= 1'b0;
    else
      transparent <= rd_valid && idx_zero;
  end
`endif

  always_comb begin
    target     = fade_in ? FULL : 5'd0;
    next_level = fade_in ? level + 5'd1 : level - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      level     <= FULL;
      div       <= '0;
      fade_in   <= 1'b0;
      fade_busy <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      fade_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fade_start) begin
            fade_in   <= fade_dir;
            div       <= '0;
            fade_busy <= 1'b1;
            state     <= STEP;
          end
        end
        STEP: begin
          // Only reachable on the first STEP cycle: stepping exits on reaching target.
          if (level == target) begin
            fade_done <= 1'b1;
            fade_busy <= 1'b0;
            state     <= IDLE;
          end else if (div == DIV_W'(FADE_DIV - 1)) begin
            div   <= '0;
            level <= next_level;
            if (next_level == target) begin
              fade_done <= 1'b1;
              fade_busy <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_ram_fader.sv
// Randomised and directed bench for palette_ram_fader against a cycle-level behavioural model.
module tb_palette_ram_fader;
  localparam int NB = 3;
  localparam int NE = 32;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_bank = '0;
  logic [4:0]  pix_index = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_bank = '0;
  logic [4:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic [3:0]  red, green, blue;
  logic        out_valid, fade_busy, fade_done;
`ifdef PALETTE_TRANSPARENCY_EN
  logic        transparent;
`endif

  palette_ram_fader #(
    .NUM_ENTRIES(NE),
    .NUM_BANKS(NB),
    .CH_W(4),
    .FADE_DIV(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_bank(pix_bank), .pix_index(pix_index),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .fade_start(fade_start), .fade_dir(fade_dir),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .fade_busy(fade_busy), .fade_done(fade_done)
`ifdef PALETTE_TRANSPARENCY_EN
    , .transparent(transparent)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: palette contents, one pending lookup, expected outputs, fade progress.
  logic [11:0] ram [NB][NE];
  int   m_level = 16;
  bit   m_busy = 0, m_done = 0, m_dir = 0;
  int   m_j = 0, m_S = 0, m_L0 = 16;
  bit   p_valid = 0, p_zero = 0;
  logic [11:0] p_col = '0;
  bit   e_valid = 0, e_transp = 0;
  logic [11:0] e_col = '0;

  function automatic logic [3:0] sc(input logic [3:0] c, input int lvl);
    return 4'((int'(c) * lvl) / 16);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_level = 16; m_busy = 0; m_done = 0;
      p_valid = 0; e_valid = 0; e_col = '0; e_transp = 0;
      return;
    end
    e_valid  = p_valid;
    e_transp = p_valid && p_zero;
    if (p_valid)
      e_col = {sc(p_col[11:8], m_level), sc(p_col[7:4], m_level), sc(p_col[3:0], m_level)};
    p_valid = pix_valid;
    if (pix_valid) begin
      p_col  = (int'(pix_bank) < NB) ? ram[pix_bank][pix_index] : 12'h000;
      p_zero = (pix_index == 0);
    end
    if (wr_en && int'(wr_bank) < NB)
      ram[wr_bank][wr_addr] = wr_data;
    m_done = 0;
    if (m_busy) begin
      m_j++;
      if (m_S > 0)
        m_level = m_dir ? m_L0 + m_j / FD : m_L0 - m_j / FD;
      if (m_S == 0 || m_j == m_S * FD) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (fade_start) begin
      m_busy = 1; m_j = 0; m_dir = fade_dir; m_L0 = m_level;
      m_S = fade_dir ? 16 - m_level : m_level;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check_cycle();
    chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("fade_busy", {31'd0, fade_busy}, {31'd0, m_busy});
    chk("fade_done", {31'd0, fade_done}, {31'd0, m_done});
    chk("colour", {20'd0, red, green, blue}, {20'd0, e_col});
`ifdef PALETTE_TRANSPARENCY_EN
    chk("transparent", {31'd0, transparent}, {31'd0, e_transp});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wr(input logic [1:0] b, input logic [4:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Issues a lookup and advances to the cycle where its result is on the outputs.
  task automatic lookup(input logic [1:0] b, input logic [4:0] i);
    pix_valid = 1'b1; pix_bank = b; pix_index = i;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int k0, input string name);
    while (!fade_done && cyc - k0 < 200) tick();
    chk(name, cyc - k0, 64);
  endtask

  initial begin
    int k0;
    int pulses;

    tick(); tick();
    chk("reset_colour", {20'd0, red, green, blue}, 0);
    chk("reset_valid", {31'd0, out_valid}, 0);
    chk("reset_busy", {31'd0, fade_busy}, 0);
    reset = 1'b0;

    for (int b = 0; b < NB; b++)
      for (int i = 0; i < NE; i++)
        wr(2'(b), 5'(i), 12'($urandom));
    wr(2'd0, 5'd5, 12'hA43);
    wr(2'd1, 5'd7, 12'hFFF);
    wr(2'd0, 5'd9, 12'hF84);
    wr(2'd0, 5'd10, 12'hFFF);
    wr(2'd2, 5'd0, 12'h5A5);
    wr(2'd2, 5'd1, 12'h3C3);
    wr(2'd3, 5'd4, 12'hABC);

    lookup(2'd0, 5'd5);
    chk("lookup_valid", {31'd0, out_valid}, 1);
    chk("lookup_a43", {20'd0, red, green, blue}, 12'hA43);

    // Same-cycle write and lookup of one entry, then a repeat lookup.
    wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 5'd7; wr_data = 12'h123;
    pix_valid = 1'b1; pix_bank = 2'd1; pix_index = 5'd7;
    tick();
    wr_en = 1'b0;
    tick();
    chk("rbw_old", {20'd0, red, green, blue}, 12'hFFF);
    pix_valid = 1'b0;
    tick();
    chk("rbw_new", {20'd0, red, green, blue}, 12'h123);

    // Fade out: level 15 visible from the 4th cycle after start.
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    k0 = cyc;
    chk("busy_after_start", {31'd0, fade_busy}, 1);
    tick(); tick(); tick();
    lookup(2'd0, 5'd10);
    chk("level15", {20'd0, red, green, blue}, 12'hEEE);
    wait_done(k0, "fade_out_cycles");
    tick();
    chk("busy_after_done", {31'd0, fade_busy}, 0);
    lookup(2'd0, 5'd10);
    chk("faded_black", {20'd0, red, green, blue}, 12'h000);

    // Already at target: done pulse one cycle after start.
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    tick();
    chk("at_target_done", {31'd0, fade_done}, 1);
    tick();

    // Fade in with an ignored mid-fade start of opposite direction.
    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    k0 = cyc;
    while (cyc - k0 < 31) begin
      fade_start = (cyc - k0 == 10);
      fade_dir = 1'b0;
      tick();
    end
    fade_start = 1'b0;
    lookup(2'd0, 5'd9);
    chk("level8_f84", {20'd0, red, green, blue}, 12'h742);
    wait_done(k0, "fade_in_cycles");
    lookup(2'd0, 5'd10);
    chk("fade_in_full", {20'd0, red, green, blue}, 12'hFFF);

    // Reset mid-fade.
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    k0 = cyc;
    while (cyc - k0 < 20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_busy", {31'd0, fade_busy}, 0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (fade_done) pulses++;
    end
    chk("reset_mid_no_done", pulses, 0);
    for (int i = 0; i < NE; i++) begin
      pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 5'(i);
      tick();
    end
    pix_valid = 1'b0;
    tick(); tick();

    lookup(2'd2, 5'd0);
    chk("bank2_idx0", {20'd0, red, green, blue}, 12'h5A5);
`ifdef PALETTE_TRANSPARENCY_EN
    chk("transp_idx0", {31'd0, transparent}, 1);
`endif
    lookup(2'd2, 5'd1);
    chk("bank2_idx1", {20'd0, red, green, blue}, 12'h3C3);
`ifdef PALETTE_TRANSPARENCY_EN
    chk("transp_idx1", {31'd0, transparent}, 0);
`endif
    lookup(2'd3, 5'd4);
    chk("bank_oob", {20'd0, red, green, blue}, 12'h000);

    for (int i = 0; i < 3000; i++) begin
      pix_valid  = ($urandom % 4) != 0;
      pix_bank   = 2'($urandom);
      pix_index  = 5'($urandom);
      wr_en      = ($urandom % 3) == 0;
      wr_bank    = 2'($urandom);
      wr_addr    = 5'($urandom);
      wr_data    = 12'($urandom);
      fade_start = ($urandom % 150) == 0;
      fade_dir   = 1'($urandom);
      reset      = ($urandom % 700) == 0;
      tick();
    end
    reset = 1'b0; pix_valid = 1'b0; wr_en = 1'b0; fade_start = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
